// File: rtl/alu_operand_sel.sv
// Parametrised N-source operand selector for the ALU input path: selects one source,
// registers it behind a valid/ready handshake with a one-beat skid buffer, flags illegal codes.
module alu_operand_sel #(
    parameter int WIDTH        = 8,
    parameter int NUM_SRC      = 4,
    parameter int SEL_W        = 2,
    parameter bit ILLEGAL_ZERO = 1'b1
) (
    input  logic                     CLK,
    input  logic                     NRST,
    input  logic [NUM_SRC*WIDTH-1:0] SRC_DATA,
    input  logic [SEL_W-1:0]         SRC,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    output logic [WIDTH-1:0]         OUT_DATA,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic                     ERR,
    input  logic                     ERR_CLR
);

    logic [WIDTH-1:0] out_data_r;
    logic [WIDTH-1:0] out_data_s;
    logic             out_valid_r;
    logic             out_valid_s;
    logic [WIDTH-1:0] skid_data_r;
    logic [WIDTH-1:0] skid_data_s;
    logic             skid_valid_r;
    logic             skid_valid_s;
    logic             in_ready_r;
    logic             in_ready_s;
    logic             err_r;
    logic             err_s;

    logic [WIDTH-1:0] sel_data_s;
    logic             legal_s;
    logic             accept_s;
    logic             enq_s;
    logic [WIDTH-1:0] enq_data_s;
    logic             oreg_free_s;

    // Source mux and classification of the presented beat.
    always_comb begin
        sel_data_s = {WIDTH{1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            sel_data_s = (SRC == SEL_W'(i)) ? SRC_DATA[i*WIDTH +: WIDTH] : sel_data_s;
        end
        legal_s     = (int'(SRC) < NUM_SRC);
        accept_s    = IN_VALID & in_ready_r;
        // An illegal beat is still accepted; ILLEGAL_ZERO decides whether it travels on as zero.
        enq_s       = accept_s & (legal_s | ILLEGAL_ZERO);
        enq_data_s  = legal_s ? sel_data_s : {WIDTH{1'b0}};
        oreg_free_s = ~out_valid_r | OUT_READY;
    end

    // Next-state for output register, skid register, ready flop and sticky error.
    always_comb begin
        out_data_s   = out_data_r;
        out_valid_s  = out_valid_r;
        skid_data_s  = skid_data_r;
        skid_valid_s = skid_valid_r;
        if (oreg_free_s) begin
            if (skid_valid_r) begin
                out_data_s  = skid_data_r;
                out_valid_s = 1'b1;
                if (enq_s) begin
                    skid_data_s  = enq_data_s;
                    skid_valid_s = 1'b1;
                end else begin
                    skid_valid_s = 1'b0;
                end
            end else if (enq_s) begin
                out_data_s  = enq_data_s;
                out_valid_s = 1'b1;
            end else begin
                out_valid_s = 1'b0;
            end
        end else if (enq_s) begin
            skid_data_s  = enq_data_s;
            skid_valid_s = 1'b1;
        end else begin
            skid_valid_s = skid_valid_r;
        end
        in_ready_s = ~skid_valid_s;
        // A new illegal accept outranks a same-cycle clear.
        if (accept_s & ~legal_s) begin
            err_s = 1'b1;
        end else if (ERR_CLR) begin
            err_s = 1'b0;
        end else begin
            err_s = err_r;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            out_data_r   <= {WIDTH{1'b0}};
            out_valid_r  <= 1'b0;
            skid_data_r  <= {WIDTH{1'b0}};
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
            err_r        <= 1'b0;
        end else begin
            out_data_r   <= out_data_s;
            out_valid_r  <= out_valid_s;
            skid_data_r  <= skid_data_s;
            skid_valid_r <= skid_valid_s;
            in_ready_r   <= in_ready_s;
            err_r        <= err_s;
        end
    end

    assign IN_READY  = in_ready_r;
    assign OUT_DATA  = out_data_r;
    assign OUT_VALID = out_valid_r;
    assign ERR       = err_r;

endmodule
